if_buf: RTL and testbench

IF_BUF -- requirements
Module: if_buf

---
 rtl/if_buf_pkg.sv | 27 ++
 rtl/if_buf.sv | 143 ++++++++++++++
 tb/tb_if_buf.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_buf_pkg.sv
// Shared widths and entry field layout for the instruction fetch buffer.
// The layout macros are the single place the entry format is defined;
// the package re-exports them as typed localparams for the RTL and bench.
`ifndef IF_BUF_DEFINES
`define IF_BUF_DEFINES
`define PC_WIDTH            32
`define INSTR_WIDTH         32
`define ENT_BUS_ERR_OFS     0
`define ENT_MISALIGN_OFS    1
`define ENT_PRDT_OFS        2
`define ENT_INSTR_OFS       3
`define ENT_PC_OFS          (`ENT_INSTR_OFS + `INSTR_WIDTH)
`define ENT_WIDTH           (`ENT_PC_OFS + `PC_WIDTH)
`endif

package if_buf_pkg;

    localparam int PC_W         = `PC_WIDTH;
    localparam int INSTR_W      = `INSTR_WIDTH;
    localparam int ENT_W        = `ENT_WIDTH;
    localparam int PC_OFS       = `ENT_PC_OFS;
    localparam int INSTR_OFS    = `ENT_INSTR_OFS;
    localparam int PRDT_OFS     = `ENT_PRDT_OFS;
    localparam int MISALIGN_OFS = `ENT_MISALIGN_OFS;
    localparam int BUS_ERR_OFS  = `ENT_BUS_ERR_OFS;

endpackage

// File: rtl/if_buf.sv
// Instruction fetch buffer between IF and ID: a circular buffer of fetched
// entries with optional same-cycle bypass when empty, and an optional hold
// that stops further fetches once an entry carrying a fetch exception is in.
module if_buf
    import if_buf_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter bit BYPASS       = 1'b0,
    parameter bit HOLD_ON_EXCP = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    input  logic [PC_W-1:0]          if_pc_i,
    input  logic [INSTR_W-1:0]       if_instr_i,
    input  logic                     if_prdt_taken_i,
    input  logic                     if_excp_misalign_i,
    input  logic                     if_excp_bus_err_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [PC_W-1:0]          id_pc_o,
    output logic [INSTR_W-1:0]       id_instr_o,
    output logic                     id_prdt_taken_o,
    output logic                     id_excp_misalign_o,
    output logic                     id_excp_bus_err_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             excp_hold;

    logic [ENT_W-1:0] in_entry;
    logic [ENT_W-1:0] head_entry;
    logic [ENT_W-1:0] out_entry;
    logic             empty;
    logic             bypass_path;
    logic             push;
    logic             pop;
    logic             store;
    logic             deq;
    logic             in_excp;
    logic             head_excp;

    // Pack the incoming IF fields into one storage word.
    always_comb begin
        in_entry = '0;
        in_entry[PC_OFS +: PC_W]       = if_pc_i;
        in_entry[INSTR_OFS +: INSTR_W] = if_instr_i;
        in_entry[PRDT_OFS]             = if_prdt_taken_i;
        in_entry[MISALIGN_OFS]         = if_excp_misalign_i;
        in_entry[BUS_ERR_OFS]          = if_excp_bus_err_i;
    end

    assign head_entry  = mem[rd_ptr];
    assign empty       = (count == '0);
    assign bypass_path = BYPASS && empty && !flush_i;
    assign in_excp     = if_excp_misalign_i | if_excp_bus_err_i;
    assign head_excp   = head_entry[MISALIGN_OFS] | head_entry[BUS_ERR_OFS];

    // Space is judged on the registered count only, so a pop on a full
    // buffer never opens the door for a push in the same cycle.
    assign if_ready_o = (count < FULL) && !excp_hold && !flush_i;

    // Select what ID sees: stored head, the live IF entry when bypassing an
    // empty buffer, or all zeros when nothing is valid.
    always_comb begin
        id_valid_o = 1'b0;
        out_entry  = '0;
        if (!flush_i) begin
            if (!empty) begin
                id_valid_o = 1'b1;
                out_entry  = head_entry;
            end else if (bypass_path && if_valid_i) begin
                id_valid_o = 1'b1;
                out_entry  = in_entry;
            end
        end
    end

    assign id_pc_o            = out_entry[PC_OFS +: PC_W];
    assign id_instr_o         = out_entry[INSTR_OFS +: INSTR_W];
    assign id_prdt_taken_o    = out_entry[PRDT_OFS];
    assign id_excp_misalign_o = out_entry[MISALIGN_OFS];
    assign id_excp_bus_err_o  = out_entry[BUS_ERR_OFS];
    assign count_o            = count;

    // A pop while empty can only be a bypass pass-through, which is consumed
    // without touching storage; otherwise pushes store and pops dequeue.
    assign push  = if_valid_i && if_ready_o;
    assign pop   = id_valid_o && id_ready_i;
    assign store = push && !(empty && pop);
    assign deq   = pop && !empty;

    // Storage array write; contents need no reset because the outputs are
    // masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers, occupancy and exception hold; flush clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            excp_hold <= 1'b0;
        end else if (flush_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            excp_hold <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({store, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (HOLD_ON_EXCP && store && in_excp) begin
                excp_hold <= 1'b1;
            end else if (deq && head_excp) begin
                excp_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_buf.sv
// Self-checking bench for if_buf: one instance without bypass and with the
// exception hold, one with bypass and without the hold, both sharing stimulus.
// A queue-based model predicts what the selected instance should show.
module tb_if_buf;
    import if_buf_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               pt;
        logic               mis;
        logic               be;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic if_valid;
    logic id_ready;
    ent_t din;

    logic         rdy_a, vld_a, pt_a, mis_a, be_a;
    logic [31:0]  pc_a, instr_a;
    logic [2:0]   cnt_a;
    logic         rdy_b, vld_b, pt_b, mis_b, be_b;
    logic [31:0]  pc_b, instr_b;
    logic [2:0]   cnt_b;

    ent_t         head_a, head_b, obs_head;
    logic         obs_ready, obs_valid;
    logic [2:0]   obs_count;
    bit           sel;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    ent_t       mq[$];
    bit         mh;
    bit         exp_ready, exp_valid;
    ent_t       exp_head;
    logic [2:0] exp_count;
    bit         cur_v, cur_rdy, cur_fl;
    ent_t       cur_d;

    always #5 clk = ~clk;

    if_buf #(.DEPTH(DEPTH), .BYPASS(1'b0), .HOLD_ON_EXCP(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .if_valid_i(if_valid), .if_ready_o(rdy_a),
        .if_pc_i(din.pc), .if_instr_i(din.instr),
        .if_prdt_taken_i(din.pt), .if_excp_misalign_i(din.mis), .if_excp_bus_err_i(din.be),
        .id_valid_o(vld_a), .id_ready_i(id_ready),
        .id_pc_o(pc_a), .id_instr_o(instr_a), .id_prdt_taken_o(pt_a),
        .id_excp_misalign_o(mis_a), .id_excp_bus_err_o(be_a), .count_o(cnt_a)
    );

    if_buf #(.DEPTH(DEPTH), .BYPASS(1'b1), .HOLD_ON_EXCP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .if_valid_i(if_valid), .if_ready_o(rdy_b),
        .if_pc_i(din.pc), .if_instr_i(din.instr),
        .if_prdt_taken_i(din.pt), .if_excp_misalign_i(din.mis), .if_excp_bus_err_i(din.be),
        .id_valid_o(vld_b), .id_ready_i(id_ready),
        .id_pc_o(pc_b), .id_instr_o(instr_b), .id_prdt_taken_o(pt_b),
        .id_excp_misalign_o(mis_b), .id_excp_bus_err_o(be_b), .count_o(cnt_b)
    );

    assign head_a    = {pc_a, instr_a, pt_a, mis_a, be_a};
    assign head_b    = {pc_b, instr_b, pt_b, mis_b, be_b};
    assign obs_head  = sel ? head_b : head_a;
    assign obs_ready = sel ? rdy_b : rdy_a;
    assign obs_valid = sel ? vld_b : vld_a;
    assign obs_count = sel ? cnt_b : cnt_a;

    function automatic ent_t mk(input logic [31:0] pc, input bit mis, input bit be);
        ent_t e;
        e.pc    = pc;
        e.instr = $urandom;
        e.pt    = 1'($urandom % 2);
        e.mis   = mis;
        e.be    = be;
        return e;
    endfunction

    // Expected outputs before the coming edge, from the queue contents.
    function automatic void model_peek();
        exp_ready = !cur_fl && (mq.size() < DEPTH) && !mh;
        exp_valid = 1'b0;
        exp_head  = '0;
        if (!cur_fl) begin
            if (mq.size() > 0) begin
                exp_valid = 1'b1;
                exp_head  = mq[0];
            end else if (sel && cur_v) begin
                exp_valid = 1'b1;
                exp_head  = cur_d;
            end
        end
        exp_count = 3'(mq.size());
    endfunction

    // Apply the effect of the edge that just happened.
    task automatic model_commit();
        bit   push, pop;
        ent_t e;
        if (cur_fl) begin
            mq.delete();
            mh = 1'b0;
            return;
        end
        push = cur_v && exp_ready;
        pop  = exp_valid && cur_rdy;
        if (mq.size() == 0 && push && pop) return;
        if (pop) begin
            e = mq.pop_front();
            if (e.mis || e.be) mh = 1'b0;
        end
        if (push) begin
            mq.push_back(cur_d);
            if (!sel && (cur_d.mis || cur_d.be)) mh = 1'b1;
        end
    endtask

    task automatic drive(input bit v, input ent_t d, input bit rdy, input bit fl);
        @(negedge clk);
        if_valid = v;
        din      = d;
        id_ready = rdy;
        flush    = fl;
        cur_v    = v;
        cur_d    = d;
        cur_rdy  = rdy;
        cur_fl   = fl;
        #1;
        model_peek();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
    endtask

    task automatic select_dut(input bit which);
        sel = which;
        drive(1'b0, '0, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; din = '0;
        sel = 1'b0; mq.delete(); mh = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({vld_a, head_a} !== '0) begin errors++; $display("[TB] FAIL reset_out_a: got %h expected 0", {vld_a, head_a}); end
        checks++;
        if (cnt_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_count_a: got %0d expected 0", cnt_a); end
        checks++;
        if ({vld_b, head_b} !== '0 || cnt_b !== 3'd0) begin errors++; $display("[TB] FAIL reset_b: got %h/%0d expected 0/0", {vld_b, head_b}, cnt_b); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b%b expected 11", rdy_a, rdy_b); end
    endtask

    task automatic test_fill_drain();
        ent_t sent[4];
        for (int k = 0; k < 4; k++) begin
            sent[k] = mk(32'(4 * k), 1'b0, 1'b0);
            drive(1'b1, sent[k], 1'b0, 1'b0);
            checks++;
            if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected 1", k, obs_ready); end
            advance();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_count !== 3'd4 || obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL full: got count %0d ready %b expected 4 0", obs_count, obs_ready); end
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs_valid !== 1'b1 || obs_head !== sent[k]) begin errors++; $display("[TB] FAIL drain[%0d]: got %b %h expected 1 %h", k, obs_valid, obs_head, sent[k]); end
            advance();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_count !== 3'd0 || obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL drained: got count %0d valid %b expected 0 0", obs_count, obs_valid); end
        advance();
    endtask

    task automatic test_wrap();
        drive(1'b1, mk(32'h100, 1'b0, 1'b0), 1'b0, 1'b0);
        advance();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, mk(32'(32'h100 + 4 * (k + 1)), 1'b0, 1'b0), 1'b1, 1'b0);
            checks++;
            if (obs_valid !== 1'b1 || obs_head.pc !== 32'(32'h100 + 4 * k) || obs_count !== 3'd1) begin
                errors++;
                $display("[TB] FAIL wrap[%0d]: got pc %h count %0d expected pc %h count 1", k, obs_head.pc, obs_count, 32'h100 + 4 * k);
            end
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_head.pc !== 32'h128) begin errors++; $display("[TB] FAIL wrap_last: got %b %h expected 1 128", obs_valid, obs_head.pc); end
        advance();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk(32'(32'h10 + 4 * k), 1'b0, 1'b0), 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, mk(32'h200, 1'b0, 1'b0), 1'b0, 1'b1);
        checks++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_count !== 3'd3) begin
            errors++;
            $display("[TB] FAIL flush_cycle: got ready %b valid %b count %0d expected 0 0 3", obs_ready, obs_valid, obs_count);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs_valid !== 1'b0 || obs_count !== 3'd0 || obs_head !== '0) begin
                errors++;
                $display("[TB] FAIL after_flush[%0d]: got valid %b count %0d pc %h expected 0 0 0", k, obs_valid, obs_count, obs_head.pc);
            end
            advance();
        end
    endtask

    task automatic test_excp_hold();
        drive(1'b1, mk(32'h3C, 1'b0, 1'b0), 1'b0, 1'b0);
        advance();
        drive(1'b1, mk(32'h40, 1'b0, 1'b1), 1'b0, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk(32'h44, 1'b0, 1'b0), 1'b0, 1'b0);
            checks++;
            if (obs_ready !== 1'b0 || obs_count !== 3'd2) begin errors++; $display("[TB] FAIL hold[%0d]: got ready %b count %0d expected 0 2", k, obs_ready, obs_count); end
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_head.pc !== 32'h3C || obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_pop1: got pc %h ready %b expected 3c 0", obs_head.pc, obs_ready); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_head.pc !== 32'h40 || obs_head.be !== 1'b1 || obs_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_pop2: got pc %h be %b ready %b expected 40 1 0", obs_head.pc, obs_head.be, obs_ready);
        end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1 || obs_count !== 3'd0) begin errors++; $display("[TB] FAIL hold_release: got ready %b count %0d expected 1 0", obs_ready, obs_count); end
        advance();
    endtask

    task automatic test_bypass();
        ent_t e;
        select_dut(1'b1);
        e = mk(32'h80, 1'b0, 1'b0);
        drive(1'b1, e, 1'b1, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_head !== e || obs_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bypass_pass: got %b %h count %0d expected 1 %h 0", obs_valid, obs_head, obs_count, e);
        end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_count !== 3'd0 || {obs_valid, obs_head} !== '0) begin errors++; $display("[TB] FAIL bypass_empty: got count %0d out %h expected 0 0", obs_count, {obs_valid, obs_head}); end
        advance();
        e = mk(32'h84, 1'b0, 1'b0);
        drive(1'b1, e, 1'b0, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_head !== e) begin errors++; $display("[TB] FAIL bypass_show: got %b %h expected 1 %h", obs_valid, obs_head, e); end
        advance();
        drive(1'b1, mk(32'h88, 1'b0, 1'b1), 1'b0, 1'b0);
        checks++;
        if (obs_count !== 3'd1 || obs_head !== e) begin errors++; $display("[TB] FAIL bypass_stored: got count %0d %h expected 1 %h", obs_count, obs_head, e); end
        advance();
        drive(1'b1, mk(32'h8C, 1'b0, 1'b0), 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1 || obs_count !== 3'd2) begin errors++; $display("[TB] FAIL no_hold: got ready %b count %0d expected 1 2", obs_ready, obs_count); end
        advance();
    endtask

    task automatic test_random(input bit which, input int n);
        bit   v, rdy, fl;
        ent_t e;
        select_dut(which);
        for (int i = 0; i < n; i++) begin
            v   = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            fl  = ($urandom % 32) == 0;
            e   = mk({$urandom_range(0, 255), 2'b00}, ($urandom % 16) == 0, ($urandom % 16) == 0);
            drive(v, e, rdy, fl);
            checks++;
            if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand%0d_ready[%0d]: got %b expected %b", which, i, obs_ready, exp_ready); end
            checks++;
            if ({obs_valid, obs_head} !== {exp_valid, exp_head}) begin
                errors++;
                $display("[TB] FAIL rand%0d_head[%0d]: got %b %h expected %b %h", which, i, obs_valid, obs_head, exp_valid, exp_head);
            end
            checks++;
            if (obs_count !== exp_count) begin errors++; $display("[TB] FAIL rand%0d_count[%0d]: got %0d expected %0d", which, i, obs_count, exp_count); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        select_dut(1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, mk(32'(32'h300 + 4 * k), 1'b0, 1'b0), 1'b0, 1'b0);
            advance();
        end
        @(negedge clk);
        if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0; din = '0;
        #1;
        checks++;
        if (cnt_a !== 3'd2) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 2", cnt_a); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_a !== 3'd0 || vld_a !== 1'b0 || head_a !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got count %0d valid %b pc %h expected 0 0 0", cnt_a, vld_a, pc_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mh = 1'b0;
        #1;
        checks++;
        if (rdy_a !== 1'b1) begin errors++; $display("[TB] FAIL async_release_ready: got %b expected 1", rdy_a); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_excp_hold();
        test_random(1'b0, 400);
        test_bypass();
        test_random(1'b1, 400);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
